tt_um_eight_bit_adder: RTL and testbench



---
 rtl/tt_um_eight_bit_adder.sv | 24 ++
 tb/tb_tt_um_eight_bit_adder.sv | 111 +++++++++++
 2 files changed

// File: rtl/tt_um_eight_bit_adder.sv
// tt_um_eight_bit_adder: Tiny Tapeout tile holding a registered 8-bit unsigned sum of ui_in and uio_in
module tt_um_eight_bit_adder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    logic [7:0] sum_q;
    logic       carry_q;
    // Capture the full 9-bit sum on each enabled edge; reset (rst_n high) wins over ena
    always_ff @(posedge clk) begin
        if (rst_n)
            {carry_q, sum_q} <= 9'd0;
        else if (ena)
            {carry_q, sum_q} <= {1'b0, ui_in} + {1'b0, uio_in};
    end
    assign uo_out  = sum_q;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;
endmodule

// File: tb/tb_tt_um_eight_bit_adder.sv
// tb_tt_um_eight_bit_adder: random and directed stimulus checked against an arithmetic model
module tb_tt_um_eight_bit_adder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;
    int checks = 0;
    int errors = 0;
    int exp_sum = 0;
    int exp_carry = 0;
    logic started = 1'b0;

    tt_um_eight_bit_adder dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    // Reference model: result register loaded with (a+b) mod 256 and its overflow flag
    always @(posedge clk) begin
        if (rst_n) begin
            exp_sum   <= 0;
            exp_carry <= 0;
            started   <= 1'b1;
        end else if (ena) begin
            exp_sum   <= (int'(ui_in) + int'(uio_in)) % 256;
            exp_carry <= (int'(ui_in) + int'(uio_in)) >= 256 ? 1 : 0;
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Compare every cycle on the falling edge, once the first reset edge has defined the state
    always @(negedge clk) begin
        if (started) begin
            check("uo_out", int'(uo_out), exp_sum);
            check("carry_q", int'(dut.carry_q), exp_carry);
            check("uio_out", int'(uio_out), 0);
            check("uio_oe", int'(uio_oe), 0);
        end
    end

    task automatic step(input logic r, input logic e, input int a, input int b);
        rst_n  = r;
        ena    = e;
        ui_in  = 8'(a);
        uio_in = 8'(b);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 8'hAA, 8'h55);
            check("reset_lit", int'(uo_out), 0);
        end
        step(1'b0, 1'b1, 20, 30);
        check("lit_20p30", int'(uo_out), 50);
        step(1'b0, 1'b1, 8'hFF, 8'h01);
        check("lit_wrap_ff01", int'(uo_out), 0);
        check("lit_carry_ff01", int'(dut.carry_q), 1);
        step(1'b0, 1'b1, 8'hC8, 8'h64);
        check("lit_wrap_c864", int'(uo_out), 8'h2C);
        step(1'b0, 1'b1, 8'h80, 8'h80);
        check("lit_wrap_8080", int'(uo_out), 0);
        check("lit_carry_8080", int'(dut.carry_q), 1);
        step(1'b0, 1'b1, 7, 9);
        check("lit_7p9", int'(uo_out), 16);
        check("lit_carry_7p9", int'(dut.carry_q), 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 100, 100);
            check("lit_hold", int'(uo_out), 16);
        end
        step(1'b0, 1'b1, 100, 100);
        check("lit_100p100", int'(uo_out), 200);
        for (int i = 0; i < 128; i++) begin
            step(1'b0, 1'b1, i, i);
            check("lit_b2b", int'(uo_out), 2 * i);
        end
        step(1'b0, 1'b1, 50, 60);
        step(1'b1, 1'b1, 3, 4);
        check("lit_midreset", int'(uo_out), 0);
        step(1'b0, 1'b0, 3, 4);
        check("lit_after_rel_idle", int'(uo_out), 0);
        step(1'b0, 1'b1, 3, 4);
        check("lit_resume", int'(uo_out), 7);
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
